dsec_ingress_ctrl: RTL and testbench



---
 rtl/dsec_pkg.sv | 22 ++
 rtl/dsec_sync_fifo.sv | 56 +++++
 rtl/dsec_ingress_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dsec_ingress_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsec_pkg.sv
// Shared types for the data-stream encryption ingress controller.
package dsec_pkg;

    localparam int unsigned ERR_CODE_W = 2;

    // Controller states
    typedef enum logic [1:0] {
        ST_NOKEY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    // Sticky error codes reported on error_code
    typedef enum logic [ERR_CODE_W-1:0] {
        ERR_NONE       = 2'b00,
        ERR_DATA_FIRST = 2'b01,
        ERR_LOAD_ABORT = 2'b10,
        ERR_KEY_PARITY = 2'b11
    } err_code_e;

endpackage

// File: rtl/dsec_sync_fifo.sv
// Synchronous FIFO feeding the compression stage; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module dsec_sync_fifo #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              push_ok_c;
    logic              pop_ok_c;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push_ok_c = push_i && !full_o;
    assign pop_ok_c  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Pointer advance on accepted push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok_c) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        if (pop_ok_c)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end

    // Pointer registers; reset discards contents
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since empty masks the head
    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/dsec_ingress_ctrl.sv
// Ingress controller: loads a key set, gates data until keys are present,
// buffers data toward compression and reports sticky errors.
// Optional: define DSEC_KEY_PARITY_EN to require odd parity per key byte.
module dsec_ingress_ctrl
    import dsec_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned NUM_KEYS   = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       in_valid,
    input  logic                       key_config,
    output logic                       rdy,
    output logic [NUM_KEYS*DATA_W-1:0] key_out,
    output logic                       keys_loaded,
    output logic [DATA_W-1:0]          comp_data,
    output logic                       comp_valid,
    input  logic                       comp_rdy,
    output logic                       error,
    output logic [ERR_CODE_W-1:0]      error_code,
    input  logic                       error_clr
);

    localparam int unsigned IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int unsigned LAST_IDX = NUM_KEYS - 1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  slot_c;
    logic [DATA_W-1:0] key_q [NUM_KEYS];
    logic [DATA_W-1:0] key_d [NUM_KEYS];
    logic              loaded_q, loaded_d;
    logic              err_q, err_d;
    err_code_e         code_q, code_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept_c;
    logic              push_c;
    logic              key_ok_c;

`ifdef DSEC_KEY_PARITY_EN
    // DES convention: each key byte carries odd parity
    function automatic logic key_parity_ok(input logic [DATA_W-1:0] w);
        logic ok;
        ok = 1'b1;
        for (int unsigned b = 0; b < DATA_W / 8; b++) ok = ok & (^w[b*8 +: 8]);
        return ok;
    endfunction
    assign key_ok_c = key_parity_ok(data_in);
`else
    assign key_ok_c = 1'b1;
`endif

    // Re-key waits for the FIFO to drain so buffered data keeps its key set
    assign rdy      = !rst && (state_q != ST_ERR) && !fifo_full &&
                      !((state_q == ST_RUN) && key_config && !fifo_empty);
    assign accept_c = in_valid && rdy;
    assign push_c   = accept_c && !key_config && (state_q == ST_RUN);
    // A key beat outside LOAD always starts a fresh set at slot 0
    assign slot_c   = (state_q == ST_LOAD) ? idx_q : '0;

    // Next-state, key bank and error logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        key_d    = key_q;
        loaded_d = loaded_q;
        err_d    = err_q;
        code_d   = code_q;
        case (state_q)
            ST_NOKEY, ST_LOAD, ST_RUN: begin
                if (accept_c && key_config) begin
                    if (!key_ok_c) begin
                        state_d  = ST_ERR;
                        err_d    = 1'b1;
                        code_d   = ERR_KEY_PARITY;
                        loaded_d = 1'b0;
                    end else begin
                        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                            if (IDX_W'(k) == slot_c) key_d[k] = data_in;
                        end
                        if (slot_c == IDX_W'(LAST_IDX)) begin
                            state_d  = ST_RUN;
                            loaded_d = 1'b1;
                            idx_d    = '0;
                        end else begin
                            state_d  = ST_LOAD;
                            loaded_d = 1'b0;
                            idx_d    = slot_c + IDX_W'(1);
                        end
                    end
                end else if (accept_c && (state_q == ST_NOKEY)) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                    code_d  = ERR_DATA_FIRST;
                end else if (accept_c && (state_q == ST_LOAD)) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                    code_d  = ERR_LOAD_ABORT;
                end
            end
            ST_ERR: begin
                if (error_clr) begin
                    state_d  = ST_NOKEY;
                    err_d    = 1'b0;
                    code_d   = ERR_NONE;
                    idx_d    = '0;
                    loaded_d = 1'b0;
                end
            end
            default: state_d = ST_NOKEY;
        endcase
    end

    // State and key-bank registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_NOKEY;
            idx_q    <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            for (int unsigned k = 0; k < NUM_KEYS; k++) key_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            code_q   <= code_d;
            key_q    <= key_d;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key_out
        assign key_out[k*DATA_W +: DATA_W] = key_q[k];
    end

    assign keys_loaded = loaded_q;
    assign error       = err_q;
    assign error_code  = code_q;
    assign comp_valid  = !fifo_empty;

    dsec_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .wdata_i (data_in),
        .pop_i   (comp_rdy),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (comp_data)
    );

endmodule

// File: tb/tb_dsec_ingress_ctrl.sv
// Bench for dsec_ingress_ctrl: directed beats, a queue-based reference model
// compared every cycle, and literal expectations at key points.
module tb_dsec_ingress_ctrl;

    localparam int unsigned DW    = 64;
    localparam int unsigned NK    = 3;
    localparam int unsigned DEPTH = 4;

    localparam logic [63:0] K0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K1 = 64'hFEDCBA9876543210;
`ifdef DSEC_KEY_PARITY_EN
    localparam logic [63:0] K2 = 64'h1010101010101010;
`else
    localparam logic [63:0] K2 = 64'h1111111111111111;
`endif
    localparam logic [63:0] R0 = 64'h0202020202020202;
    localparam logic [63:0] R1 = 64'h0404040404040404;
    localparam logic [63:0] R2 = 64'h0808080808080808;
    localparam logic [63:0] DA = 64'hA5A5A5A5A5A5A5A5;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     data_in;
    logic              in_valid;
    logic              key_config;
    logic              rdy;
    logic [NK*DW-1:0]  key_out;
    logic              keys_loaded;
    logic [DW-1:0]     comp_data;
    logic              comp_valid;
    logic              comp_rdy;
    logic              error;
    logic [1:0]        error_code;
    logic              error_clr;

    always #5 clk = ~clk;

    dsec_ingress_ctrl #(.DATA_W(DW), .NUM_KEYS(NK), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .key_config(key_config), .rdy(rdy), .key_out(key_out),
        .keys_loaded(keys_loaded), .comp_data(comp_data), .comp_valid(comp_valid),
        .comp_rdy(comp_rdy), .error(error), .error_code(error_code),
        .error_clr(error_clr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: key slots, count of keys in the set under construction,
    // a queue for the buffer, and the sticky error.
    logic [63:0] m_key [NK];
    logic [63:0] m_q [$];
    bit          m_loaded;
    bit          m_err;
    int          m_fill;
    logic [1:0]  m_code;
    bit          m_ready = 1'b0;

    function automatic bit m_rdy();
        if (rst || m_err) return 1'b0;
        if (m_q.size() == DEPTH) return 1'b0;
        if (m_loaded && key_config && m_q.size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit parity_ok(input logic [63:0] w);
        for (int b = 0; b < 8; b++) if (^w[b*8 +: 8] == 1'b0) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        bit pop;
        bit push;
        if (rst) begin
            for (int k = 0; k < NK; k++) m_key[k] = '0;
            m_q.delete();
            m_loaded = 1'b0;
            m_err    = 1'b0;
            m_fill   = 0;
            m_code   = 2'b00;
            m_ready  = 1'b1;
        end else if (m_ready) begin
            acc  = in_valid && m_rdy();
            pop  = comp_rdy && (m_q.size() != 0);
            push = 1'b0;
            if (m_err) begin
                if (error_clr) begin
                    m_err = 1'b0; m_code = 2'b00; m_fill = 0; m_loaded = 1'b0;
                end
            end else if (acc) begin
                if (key_config) begin
`ifdef DSEC_KEY_PARITY_EN
                    if (!parity_ok(data_in)) begin
                        m_err = 1'b1; m_code = 2'b11; m_loaded = 1'b0;
                    end else
`endif
                    begin
                        if (m_loaded) begin
                            m_loaded = 1'b0; m_fill = 0;
                        end
                        m_key[m_fill] = data_in;
                        m_fill++;
                        if (m_fill == NK) begin
                            m_loaded = 1'b1; m_fill = 0;
                        end
                    end
                end else if (m_loaded) begin
                    push = 1'b1;
                end else begin
                    m_err  = 1'b1;
                    m_code = (m_fill == 0) ? 2'b01 : 2'b10;
                end
            end
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(data_in);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_ready) begin
            check("rdy", 256'(rdy), 256'(m_rdy()));
            check("keys_loaded", 256'(keys_loaded), 256'(m_loaded));
            check("key_out", 256'(key_out), 256'({m_key[2], m_key[1], m_key[0]}));
            check("comp_valid", 256'(comp_valid), 256'(m_q.size() != 0));
            if (m_q.size() != 0) check("comp_data", 256'(comp_data), 256'(m_q[0]));
            check("error", 256'(error), 256'(m_err));
            check("error_code", 256'(error_code), 256'(m_code));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded)
    task automatic send(input bit kc, input logic [63:0] d);
        int n;
        n = 0;
        in_valid   = 1'b1;
        key_config = kc;
        data_in    = d;
        forever begin
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 256'(0), 256'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        key_config = 1'b0;
    endtask

    task automatic clear_err();
        error_clr = 1'b1;
        tick();
        error_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; key_config = 1'b0; data_in = '0;
        comp_rdy = 1'b0; error_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_rdy", 256'(rdy), 256'(0));
        check("rst_key_out", 256'(key_out), 256'(0));
        check("rst_comp_valid", 256'(comp_valid), 256'(0));
        rst = 1'b0;
        #1;
        check("post_rst_rdy", 256'(rdy), 256'(1));

        // data before any key
        send(1'b0, 64'hDEADBEEF00000001);
        #1;
        check("nokey_error", 256'(error), 256'(1));
        check("nokey_code", 256'(error_code), 256'(2'b01));
        check("nokey_rdy", 256'(rdy), 256'(0));
        check("nokey_comp_valid", 256'(comp_valid), 256'(0));
        clear_err();
        #1;
        check("clr_code", 256'(error_code), 256'(2'b00));
        check("clr_rdy", 256'(rdy), 256'(1));

        // full key set then one data word
        comp_rdy = 1'b1;
        send(1'b1, K0);
        send(1'b1, K1);
        #1;
        check("partial_loaded", 256'(keys_loaded), 256'(0));
        send(1'b1, K2);
        #1;
        check("loaded", 256'(keys_loaded), 256'(1));
        check("key_set", 256'(key_out), 256'({K2, K1, K0}));
        send(1'b0, DA);
        #1;
        check("data_valid", 256'(comp_valid), 256'(1));
        check("data_word", 256'(comp_data), 256'(DA));
        tick();
        check("data_drained", 256'(comp_valid), 256'(0));

        // backpressure: 4 words fill the buffer, the 5th waits
        comp_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) send(1'b0, 64'(i));
        in_valid = 1'b1; key_config = 1'b0; data_in = 64'd5;
        #1;
        check("full_rdy", 256'(rdy), 256'(0));
        check("full_head", 256'(comp_data), 256'(1));
        tick();
        check("full_rdy_hold", 256'(rdy), 256'(0));
        comp_rdy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check("drain_order", 256'(comp_data), 256'(i));
            tick();
            if (i == 2) in_valid = 1'b0;
        end
        check("drain_empty", 256'(comp_valid), 256'(0));

        // re-key blocked while buffer holds data
        comp_rdy = 1'b0;
        send(1'b0, 64'h77);
        in_valid = 1'b1; key_config = 1'b1; data_in = R0;
        #1;
        check("rekey_blocked", 256'(rdy), 256'(0));
        tick();
        check("rekey_blocked_hold", 256'(rdy), 256'(0));
        comp_rdy = 1'b1;
        send(1'b1, R0);
        #1;
        check("rekey_unloaded", 256'(keys_loaded), 256'(0));
        send(1'b1, R1);
        send(1'b1, R2);
        #1;
        check("rekey_loaded", 256'(keys_loaded), 256'(1));
        check("rekey_set", 256'(key_out), 256'({R2, R1, R0}));

        // reset mid-stream discards everything
        comp_rdy = 1'b0;
        send(1'b0, 64'h99);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_valid", 256'(comp_valid), 256'(0));
        check("midrst_key_out", 256'(key_out), 256'(0));
        check("midrst_rdy", 256'(rdy), 256'(1));

        // aborted key load keeps partial keys
        send(1'b1, K0);
        send(1'b1, K1);
        send(1'b0, 64'hBAD);
        #1;
        check("abort_code", 256'(error_code), 256'(2'b10));
        check("abort_loaded", 256'(keys_loaded), 256'(0));
        check("abort_keys", 256'(key_out), 256'({64'h0, K1, K0}));
        clear_err();
        #1;
        check("abort_clr_keys", 256'(key_out), 256'({64'h0, K1, K0}));
        check("abort_clr_error", 256'(error), 256'(0));

`ifdef DSEC_KEY_PARITY_EN
        // bad-parity key word is rejected
        send(1'b1, 64'h0101010101010101);
        send(1'b1, 64'h0000000000000000);
        #1;
        check("parity_code", 256'(error_code), 256'(2'b11));
        check("parity_key1", 256'(key_out[127:64]), 256'(K1));
        clear_err();
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
